regfile_wb_arb: RTL and testbench

REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

---
 rtl/regfile_wb_arb.sv | 127 ++++++++++++
 tb/tb_regfile_wb_arb.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arb.sv
// Two-requester write-back arbiter in front of a single-write-port register file.
// Each requester has a one-entry holding buffer; full buffers are granted
// round-robin and the winner is registered onto the write port.
module regfile_wb_arb #(
  parameter logic RR_START_A = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        we,
  output logic [4:0]  wt_addr,
  output logic [31:0] wdata,
  output logic [31:0] pend_mask
);

  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;
  localparam int unsigned NREG = 32;

  logic          a_full_q, a_full_d;
  logic [AW-1:0] a_addr_q, a_addr_d;
  logic [DW-1:0] a_data_q, a_data_d;
  logic          b_full_q, b_full_d;
  logic [AW-1:0] b_addr_q, b_addr_d;
  logic [DW-1:0] b_data_q, b_data_d;
  logic          last_b_q, last_b_d;
  logic          we_q, we_d;
  logic [AW-1:0] wt_addr_q, wt_addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          a_win, b_win;

  // Round-robin grant: on contention the requester not granted last wins.
  always_comb begin
    a_win   = a_full_q && (!b_full_q || last_b_q);
    b_win   = b_full_q && (!a_full_q || !last_b_q);
    a_ready = !a_full_q || a_win;
    b_ready = !b_full_q || b_win;
  end

  // Buffer reload/drain, pointer update and write-port staging.
  always_comb begin
    a_full_d  = a_full_q;
    a_addr_d  = a_addr_q;
    a_data_d  = a_data_q;
    b_full_d  = b_full_q;
    b_addr_d  = b_addr_q;
    b_data_d  = b_data_q;
    last_b_d  = last_b_q;
    we_d      = 1'b0;
    wt_addr_d = wt_addr_q;
    wdata_d   = wdata_q;

    if (a_win) begin
      a_full_d  = 1'b0;
      last_b_d  = 1'b0;
      we_d      = (a_addr_q != '0);
      wt_addr_d = a_addr_q;
      wdata_d   = a_data_q;
    end else if (b_win) begin
      b_full_d  = 1'b0;
      last_b_d  = 1'b1;
      we_d      = (b_addr_q != '0);
      wt_addr_d = b_addr_q;
      wdata_d   = b_data_q;
    end

    // A same-edge transfer refills a buffer that is draining this cycle.
    if (a_valid && a_ready) begin
      a_full_d = 1'b1;
      a_addr_d = a_addr;
      a_data_d = a_data;
    end
    if (b_valid && b_ready) begin
      b_full_d = 1'b1;
      b_addr_d = b_addr;
      b_data_d = b_data;
    end
  end

  // State registers; reset discards buffered entries without issuing them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_full_q  <= 1'b0;
      a_addr_q  <= '0;
      a_data_q  <= '0;
      b_full_q  <= 1'b0;
      b_addr_q  <= '0;
      b_data_q  <= '0;
      last_b_q  <= RR_START_A;
      we_q      <= 1'b0;
      wt_addr_q <= '0;
      wdata_q   <= '0;
    end else begin
      a_full_q  <= a_full_d;
      a_addr_q  <= a_addr_d;
      a_data_q  <= a_data_d;
      b_full_q  <= b_full_d;
      b_addr_q  <= b_addr_d;
      b_data_q  <= b_data_d;
      last_b_q  <= last_b_d;
      we_q      <= we_d;
      wt_addr_q <= wt_addr_d;
      wdata_q   <= wdata_d;
    end
  end

  // Registers with a buffered, not yet issued write; r0 is never pending.
  always_comb begin
    pend_mask = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      pend_mask[i] = (a_full_q && (a_addr_q == AW'(i))) ||
                     (b_full_q && (b_addr_q == AW'(i)));
    end
  end

  assign we      = we_q;
  assign wt_addr = wt_addr_q;
  assign wdata   = wdata_q;

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Bench for regfile_wb_arb: directed scenarios plus random traffic, all
// checked each cycle against a transaction-level model of the two buffers.
module tb_regfile_wb_arb;

  logic        clk, rst;
  logic        a_valid, a_ready, b_valid, b_ready, we;
  logic [4:0]  a_addr, b_addr, wt_addr;
  logic [31:0] a_data, b_data, wdata, pend_mask;

  regfile_wb_arb dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .we(we), .wt_addr(wt_addr), .wdata(wdata), .pend_mask(pend_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Model: index 0 = requester A, 1 = requester B.
  logic        mf[2];
  logic [4:0]  ma[2];
  logic [31:0] md[2];
  int          mlast;
  logic        mwe;
  logic [4:0]  mwa;
  logic [31:0] mwd;

  logic [31:0] rf[32];
  logic [4:0]  log_addr[$];
  logic [31:0] log_data[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mf[i] = 1'b0; ma[i] = '0; md[i] = '0;
    end
    mlast = 1;  // A gets priority first: B counts as last granted
    mwe = 1'b0; mwa = '0; mwd = '0;
  endtask

  task automatic clear_logs();
    log_addr.delete();
    log_data.delete();
    for (int i = 0; i < 32; i++) rf[i] = '0;
  endtask

  // One clock cycle: drive, check against model, advance model, step clock.
  task automatic cycle(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    int          win;
    logic        rdy[2];
    logic [31:0] pend;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    #2;
    win = -1;
    if (mf[0] && mf[1]) win = (mlast == 0) ? 1 : 0;
    else if (mf[0])     win = 0;
    else if (mf[1])     win = 1;
    rdy[0] = !mf[0] || (win == 0);
    rdy[1] = !mf[1] || (win == 1);
    pend = '0;
    for (int i = 0; i < 2; i++) if (mf[i]) pend = pend | (32'h1 << ma[i]);
    pend[0] = 1'b0;
    chk("a_ready",   32'(a_ready), 32'(rdy[0]));
    chk("b_ready",   32'(b_ready), 32'(rdy[1]));
    chk("pend_mask", pend_mask, pend);
    chk("we",        32'(we), 32'(mwe));
    chk("wt_addr",   32'(wt_addr), 32'(mwa));
    chk("wdata",     wdata, mwd);
    if (we === 1'b1) begin
      log_addr.push_back(wt_addr);
      log_data.push_back(wdata);
      rf[wt_addr] = wdata;
    end
    if (win >= 0) begin
      mwe = (ma[win] != 5'd0); mwa = ma[win]; mwd = md[win];
      mlast = win; mf[win] = 1'b0;
    end else begin
      mwe = 1'b0;
    end
    if (av && rdy[0]) begin mf[0] = 1'b1; ma[0] = aa; md[0] = ad; end
    if (bv && rdy[1]) begin mf[1] = 1'b1; ma[1] = ba; md[1] = bd; end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    clear_logs();
  endtask

  int a_cnt, w_cnt, late;

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    model_reset();
    clear_logs();
    #2;
    chk("rst_we",      32'(we), 32'h0);
    chk("rst_wt_addr", 32'(wt_addr), 32'h0);
    chk("rst_wdata",   wdata, 32'h0);
    chk("rst_pend",    pend_mask, 32'h0);
    chk("rst_a_ready", 32'(a_ready), 32'h1);
    chk("rst_b_ready", 32'(b_ready), 32'h1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // A alone streams one write per cycle.
    cycle(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'h0);
    cycle(1'b1, 5'd4, 32'h22, 1'b0, 5'd0, 32'h0);
    cycle(1'b1, 5'd5, 32'h33, 1'b0, 5'd0, 32'h0);
    idle(4);
    chk("a_only_nwr", 32'(log_addr.size()), 32'd3);
    if (log_addr.size() == 3) begin
      chk("a_only_addr0", 32'(log_addr[0]), 32'd3);
      chk("a_only_addr2", 32'(log_addr[2]), 32'd5);
      chk("a_only_data1", log_data[1], 32'h22);
    end

    // Same destination from both: A issues first, B's value is final.
    do_reset();
    cycle(1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 32'h2);
    idle(4);
    chk("same_addr_nwr", 32'(log_addr.size()), 32'd2);
    if (log_data.size() == 2) chk("same_addr_first", log_data[0], 32'h1);
    chk("same_addr_rf9", rf[9], 32'h2);

    // Write to r0 is accepted but never issued.
    clear_logs();
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hDEADBEEF);
    idle(3);
    chk("r0_nwr", 32'(log_addr.size()), 32'd0);

    // Continuous contention alternates A,B,A,B.
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 5'd7, 32'hAAAA0000, 1'b1, 5'd8, 32'h0000BBBB);
    idle(4);
    if (log_addr.size() >= 4) begin
      chk("alt_w0", 32'(log_addr[0]), 32'd7);
      chk("alt_w1", 32'(log_addr[1]), 32'd8);
      chk("alt_w2", 32'(log_addr[2]), 32'd7);
      chk("alt_w3", 32'(log_addr[3]), 32'd8);
    end else chk("alt_nwr", 32'(log_addr.size()), 32'd7);

    // Sustained backpressure: 20-cycle window of writes, 10 from each side.
    do_reset();
    for (int i = 0; i < 20; i++)
      cycle(1'b1, 5'(1 + (i % 15)), $urandom, 1'b1, 5'(16 + (i % 16)), $urandom);
    idle(4);
    a_cnt = 0; w_cnt = 0;
    for (int i = 0; i < 20 && i < log_addr.size(); i++) begin
      w_cnt++;
      if (log_addr[i] < 5'd16) a_cnt++;
    end
    chk("bp_writes", 32'(w_cnt), 32'd20);
    chk("bp_a_writes", 32'(a_cnt), 32'd10);

    // Asynchronous reset while both buffers hold entries.
    do_reset();
    cycle(1'b1, 5'd12, 32'hC, 1'b1, 5'd13, 32'hD);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    a_valid = 1'b0; b_valid = 1'b0;
    #2;
    chk("mid_we_before", 32'(we), 32'h1);
    chk("mid_pend_before", pend_mask, 32'h1 << 13);
    rst = 1'b1;
    #1;
    chk("mid_we_after", 32'(we), 32'h0);
    chk("mid_pend_after", pend_mask, 32'h0);
    chk("mid_a_ready", 32'(a_ready), 32'h1);
    chk("mid_b_ready", 32'(b_ready), 32'h1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    clear_logs();
    idle(4);
    late = 0;
    foreach (log_addr[i]) if (log_addr[i] == 5'd12 || log_addr[i] == 5'd13) late++;
    chk("mid_no_late_wr", 32'(late), 32'd0);

    // Random traffic, including r0 and matching addresses.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom);
    idle(3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
